triangle_loader: RTL

TRIANGLE_LOADER -- requirements
Module: triangle_loader

---
 rtl/vertex_pkg.sv | 50 +++++
 rtl/triangle_loader_asm.sv | 56 +++++
 rtl/triangle_loader.sv | 129 ++++++++++++
 3 files changed

// File: rtl/vertex_pkg.sv
// Shared vertex/triangle types and host command-stream constants for the triangle loader.
// Triangles are stored packed with v0 in the most significant bits.
package vertex_pkg;

    typedef logic signed [31:0] q16_16_t;

    typedef struct packed {
        q16_16_t x;
        q16_16_t y;
        q16_16_t z;
    } vec3_t;

    typedef struct packed {
        vec3_t       pos;
        logic [11:0] color;
    } vertex_t;

    typedef struct packed {
        vertex_t v0;
        vertex_t v1;
        vertex_t v2;
    } triangle_t;

    localparam logic [7:0] SYNC_BYTE   = 8'hA5;
    localparam logic [7:0] CMD_TRI     = 8'h01;
    localparam logic [7:0] CMD_COMMIT  = 8'h02;
    localparam logic [7:0] CMD_RESTART = 8'h03;

    localparam int TRI_BYTES    = 42;
    localparam int VERTEX_BYTES = 14;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_PAYLOAD,
        ST_WRITE,
        ST_COMMIT
    } ld_state_t;

    // Position words arrive little-endian, so byte k of the vertex sits at bits [8k+7:8k].
    function automatic vertex_t unpack_vertex(input logic [95:0] pos_b, input logic [11:0] col_b);
        vertex_t v;
        v.pos.x = $signed(pos_b[31:0]);
        v.pos.y = $signed(pos_b[63:32]);
        v.pos.z = $signed(pos_b[95:64]);
        v.color = col_b;
        return v;
    endfunction

endpackage

// File: rtl/triangle_loader_asm.sv
// tri_byte_assembler: 42-byte shift register with a byte counter; full_o flags the byte
// that completes a triangle, and tri_o is the decoded triangle held in the register.
module tri_byte_assembler
    import vertex_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr_i,
    input  logic       shift_i,
    input  logic [7:0] byte_i,
    output triangle_t  tri_o,
    output logic       full_o
);

    localparam int CNT_W = $clog2(TRI_BYTES);
    localparam int SR_W  = TRI_BYTES * 8;
    localparam int VB    = VERTEX_BYTES * 8;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SR_W-1:0]  sr_q, sr_d;

    always_comb begin
        cnt_d  = cnt_q;
        sr_d   = sr_q;
        full_o = 1'b0;
        if (clr_i) begin
            cnt_d = '0;
        end else if (shift_i) begin
            // New bytes enter at the top; after 42 shifts byte 0 rests at the bottom.
            sr_d = {byte_i, sr_q[SR_W-1:8]};
            if (cnt_q == CNT_W'(TRI_BYTES - 1)) begin
                full_o = 1'b1;
                cnt_d  = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        sr_q <= sr_d;
    end

    assign tri_o.v0 = unpack_vertex(sr_q[0*VB +: 96], sr_q[0*VB+96 +: 12]);
    assign tri_o.v1 = unpack_vertex(sr_q[1*VB +: 96], sr_q[1*VB+96 +: 12]);
    assign tri_o.v2 = unpack_vertex(sr_q[2*VB +: 96], sr_q[2*VB+96 +: 12]);

endmodule

// File: rtl/triangle_loader.sv
// Host byte-stream parser that assembles triangles, writes them to the triangle RAM and
// publishes the committed triangle count to the feeder.
module triangle_loader
    import vertex_pkg::*;
#(
    parameter int N_TRIS = 430,
    parameter int ADDR_W = $clog2(N_TRIS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        in_byte,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              feeder_busy,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output triangle_t         mem_wdata,
    output logic [ADDR_W:0]   tri_count,
    output logic              done,
    output logic              err
);

    localparam logic [ADDR_W:0] MAX_PTR = (ADDR_W+1)'(N_TRIS);

    ld_state_t       state_q, state_d;
    logic [ADDR_W:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0] tri_count_q, tri_count_d;
    logic            ready_en_q;

    logic            accept;
    logic            asm_clr, asm_shift, asm_full;
    logic            we_c, done_c, err_c;
    triangle_t       asm_triangle;

    tri_byte_assembler u_asm (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_i   (asm_clr),
        .shift_i (asm_shift),
        .byte_i  (in_byte),
        .tri_o   (asm_triangle),
        .full_o  (asm_full)
    );

    // ready_en_q keeps in_ready low until the first edge after reset is released.
    assign in_ready = ready_en_q &&
                      (state_q == ST_IDLE || state_q == ST_CMD || state_q == ST_PAYLOAD);
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        tri_count_d = tri_count_q;
        asm_clr     = 1'b0;
        asm_shift   = 1'b0;
        we_c        = 1'b0;
        done_c      = 1'b0;
        err_c       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept && in_byte == SYNC_BYTE) state_d = ST_CMD;
            end
            ST_CMD: begin
                if (accept) begin
                    case (in_byte)
                        CMD_TRI: begin
                            asm_clr = 1'b1;
                            state_d = ST_PAYLOAD;
                        end
                        CMD_COMMIT:  state_d = ST_COMMIT;
                        CMD_RESTART: begin
                            wr_ptr_d = '0;
                            state_d  = ST_IDLE;
                        end
                        default: begin
                            err_c   = 1'b1;
                            state_d = ST_IDLE;
                        end
                    endcase
                end
            end
            ST_PAYLOAD: begin
                // Every payload byte is data, including 0xA5.
                asm_shift = accept;
                if (asm_full) state_d = ST_WRITE;
            end
            ST_WRITE: begin
                if (wr_ptr_q < MAX_PTR) begin
                    we_c     = 1'b1;
                    wr_ptr_d = wr_ptr_q + 1'b1;
                end else begin
                    err_c = 1'b1;
                end
                state_d = ST_IDLE;
            end
            ST_COMMIT: begin
                if (!feeder_busy) begin
                    tri_count_d = wr_ptr_q;
                    wr_ptr_d    = '0;
                    done_c      = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            wr_ptr_q    <= '0;
            tri_count_q <= '0;
            ready_en_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            tri_count_q <= tri_count_d;
            ready_en_q  <= 1'b1;
        end
    end

    assign mem_we    = we_c && rst_n;
    assign done      = done_c && rst_n;
    assign err       = err_c && rst_n;
    assign mem_addr  = wr_ptr_q[ADDR_W-1:0];
    assign mem_wdata = asm_triangle;
    assign tri_count = tri_count_q;

endmodule
